// File: rtl/watchdog_pkg.sv
// Shared types and default widths for the TileLink forward-progress watchdog.
package watchdog_pkg;

  localparam int unsigned WD_LIMIT_W_DEF      = 32;
  localparam int unsigned WD_MAX_INFLIGHT_DEF = 8;

  typedef enum logic [1:0] {
    WD_IDLE     = 2'd0,
    WD_BUSY     = 2'd1,
    WD_EXPIRED  = 2'd2
  } wd_state_e;

endpackage

// File: rtl/wd_inflight_counter.sv
// Saturating outstanding-transaction counter with overflow/underflow strobes.
module wd_inflight_counter
  import watchdog_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = WD_MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic at_max;
  logic at_zero;

  assign at_max  = (count == MAX_CNT);
  assign at_zero = (count == '0);

  // A response arriving with nothing outstanding is dropped; a paired request still counts.
  always_comb begin
    count_nxt_c = count;
    case ({inc, dec})
      2'b11:   if (at_zero) count_nxt_c = CNT_W'(1);
      2'b10:   if (!at_max) count_nxt_c = count + CNT_W'(1);
      2'b01:   if (!at_zero) count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  assign ovf = inc & ~dec & at_max;
  assign udf = dec & at_zero;

  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else       count <= count_nxt_c;
  end

endmodule

// File: rtl/tl_progress_watchdog.sv
// Forward-progress watchdog: sticky timeout when no response completes within `limit` cycles.
// Optional protocol over/underflow flag enabled by WATCHDOG_PROTO_CHECK_EN.
module tl_progress_watchdog
  import watchdog_pkg::*;
#(
  parameter int unsigned LIMIT_W      = WD_LIMIT_W_DEF,
  parameter int unsigned MAX_INFLIGHT = WD_MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LIMIT_W-1:0] limit,
  input  logic               req_valid,
  input  logic               req_ready,
  input  logic               resp_valid,
  input  logic               resp_ready,
  output logic [CNT_W-1:0]   inflight,
  output logic [LIMIT_W-1:0] stall_cycles,
  output logic               timeout,
  output logic               proto_err
);

  logic               req_fire;
  logic               resp_fire;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               limit_hit;
  logic               stall_sat;
  wd_state_e          state_q;
  wd_state_e          state_nxt;
  logic [LIMIT_W-1:0] stall_nxt;
  logic               timeout_nxt;

  assign req_fire  = req_valid & req_ready;
  assign resp_fire = resp_valid & resp_ready;

  // >= rather than == so a limit lowered below the running timer still trips.
  assign limit_hit = (limit != '0) && (stall_cycles >= (limit - LIMIT_W'(1)));
  assign stall_sat = (stall_cycles == '1);

`ifdef WATCHDOG_PROTO_CHECK_EN
  logic ovf;
  logic udf;

  wd_inflight_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clock       (clock),
    .reset       (reset),
    .inc         (req_fire),
    .dec         (resp_fire),
    .count       (inflight),
    .count_nxt_c (cnt_nxt),
    .ovf         (ovf),
    .udf         (udf)
  );

  always_ff @(posedge clock) begin
    if (reset) proto_err <= 1'b0;
    else       proto_err <= proto_err | ovf | udf;
  end
`else
  wd_inflight_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clock       (clock),
    .reset       (reset),
    .inc         (req_fire),
    .dec         (resp_fire),
    .count       (inflight),
    .count_nxt_c (cnt_nxt),
    .ovf         (),
    .udf         ()
  );

  assign proto_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= WD_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      WD_IDLE: begin
        if (cnt_nxt != '0) state_nxt = WD_BUSY;
      end
      WD_BUSY: begin
        if (limit_hit && !resp_fire) state_nxt = WD_EXPIRED;
        else if (cnt_nxt == '0)      state_nxt = WD_IDLE;
      end
      WD_EXPIRED: state_nxt = WD_EXPIRED;
      default:    state_nxt = WD_IDLE;
    endcase
  end

  // Timer runs only while work is outstanding and unanswered; frozen once expired.
  always_comb begin
    stall_nxt   = stall_cycles;
    timeout_nxt = timeout;
    case (state_q)
      WD_IDLE: stall_nxt = '0;
      WD_BUSY: begin
        if (resp_fire)      stall_nxt = '0;
        else if (!stall_sat) stall_nxt = stall_cycles + LIMIT_W'(1);
      end
      default: stall_nxt = stall_cycles;
    endcase
    if (state_nxt == WD_EXPIRED) timeout_nxt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      timeout      <= 1'b0;
    end else begin
      stall_cycles <= stall_nxt;
      timeout      <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_tl_progress_watchdog.sv
// Scoreboard bench for tl_progress_watchdog (MAX_INFLIGHT = 2 to exercise saturation).
module tb_tl_progress_watchdog;

  localparam int unsigned LW   = 32;
  localparam int unsigned MAXI = 2;
  localparam int unsigned CW   = 2;
`ifdef WATCHDOG_PROTO_CHECK_EN
  localparam bit PROTO = 1'b1;
`else
  localparam bit PROTO = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [LW-1:0] limit;
  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [CW-1:0] inflight;
  logic [LW-1:0] stall_cycles;
  logic          timeout;
  logic          proto_err;

  tl_progress_watchdog #(
    .LIMIT_W      (LW),
    .MAX_INFLIGHT (MAXI),
    .CNT_W        (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .limit        (limit),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .inflight     (inflight),
    .stall_cycles (stall_cycles),
    .timeout      (timeout),
    .proto_err    (proto_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned   inf;
    logic [31:0]   stall;
    logic          to;
    logic          pe;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned m_inf;
  int unsigned m_st;
  logic [31:0] m_stall;
  logic        m_to;
  logic        m_pe;
  int          n_checks;
  int          n_errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: advances one clock and queues the outputs expected after the edge.
  task automatic model_step(input logic rst, input logic rf, input logic sf, input logic [31:0] lim);
    int unsigned inf_n;
    int unsigned st_n;
    logic [31:0] stall_n;
    exp_t        e;
    if (rst) begin
      inf_n = 0; st_n = 0; stall_n = '0; m_to = 1'b0; m_pe = 1'b0;
    end else begin
      if (rf && sf)  inf_n = (m_inf == 0) ? 1 : m_inf;
      else if (rf)   inf_n = (m_inf == MAXI) ? m_inf : m_inf + 1;
      else if (sf)   inf_n = (m_inf == 0) ? 0 : m_inf - 1;
      else           inf_n = m_inf;
      if (PROTO && ((rf && !sf && m_inf == MAXI) || (sf && m_inf == 0))) m_pe = 1'b1;
      stall_n = m_stall;
      st_n    = m_st;
      if (m_st == 0) begin
        stall_n = '0;
        st_n    = (inf_n > 0) ? 1 : 0;
      end else if (m_st == 1) begin
        if (sf)                          stall_n = '0;
        else if (m_stall != 32'hFFFF_FFFF) stall_n = m_stall + 32'd1;
        if (lim != 0 && !sf && m_stall >= lim - 32'd1) st_n = 2;
        else                                           st_n = (inf_n > 0) ? 1 : 0;
      end
      if (st_n == 2) m_to = 1'b1;
    end
    m_inf   = inf_n;
    m_st    = st_n;
    m_stall = stall_n;
    e.inf = m_inf; e.stall = m_stall; e.to = m_to; e.pe = m_pe;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; returns 2 time units after the edge.
  task automatic cyc(input logic rv, input logic rr, input logic sv, input logic sr);
    req_valid = rv; req_ready = rr; resp_valid = sv; resp_ready = sr;
    model_step(reset, rv & rr, sv & sr, limit);
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  always begin
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_val("sb_inflight", 64'(inflight), 64'(mon_e.inf));
      check_val("sb_stall", 64'(stall_cycles), 64'(mon_e.stall));
      check_val("sb_timeout", 64'(timeout), 64'(mon_e.to));
      check_val("sb_proto_err", 64'(proto_err), 64'(mon_e.pe));
    end
  end

  initial begin
    n_checks = 0; n_errors = 0;
    m_inf = 0; m_st = 0; m_stall = '0; m_to = 1'b0; m_pe = 1'b0;
    reset = 1'b1; limit = '0;
    req_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_ready = 1'b0;
    idle(2);
    reset = 1'b0;
    check_val("reset_inflight", 64'(inflight), 64'd0);
    check_val("reset_timeout", 64'(timeout), 64'd0);

    // Basic expiry with limit 4
    limit = 32'd4;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("basic_inflight", 64'(inflight), 64'd1);
    check_val("basic_stall_c1", 64'(stall_cycles), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      check_val("basic_stall", 64'(stall_cycles), 64'(k));
    end
    check_val("basic_no_to_c4", 64'(timeout), 64'd0);
    idle(1);
    check_val("basic_to_c5", 64'(timeout), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("basic_to_sticky", 64'(timeout), 64'd1);
    check_val("basic_inflight_drain", 64'(inflight), 64'd0);

    // Reset held two cycles while expired with work outstanding
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check_val("rst_timeout", 64'(timeout), 64'd0);
    check_val("rst_stall", 64'(stall_cycles), 64'd0);
    check_val("rst_inflight", 64'(inflight), 64'd0);
    idle(1);
    check_val("rst_idle_stall", 64'(stall_cycles), 64'd0);

    // Responses keep the timer from reaching the limit
    limit = 32'd4;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("prog_stall_c4", 64'(stall_cycles), 64'd0);
    check_val("prog_inflight_c4", 64'(inflight), 64'd1);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("prog_stall_c7", 64'(stall_cycles), 64'd0);
    check_val("prog_inflight_c7", 64'(inflight), 64'd0);
    check_val("prog_no_timeout", 64'(timeout), 64'd0);

    // Limit lowered below the running timer
    limit = 32'd100;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    check_val("lower_stall20", 64'(stall_cycles), 64'd20);
    check_val("lower_no_to", 64'(timeout), 64'd0);
    limit = 32'd10;
    idle(1);
    check_val("lower_to", 64'(timeout), 64'd1);
    do_reset();

    // limit 0 never expires but the timer still counts
    limit = '0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 999; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("dis_stall999", 64'(stall_cycles), 64'd999);
    check_val("dis_no_to", 64'(timeout), 64'd0);
    do_reset();

    // Saturation and underflow
    limit = 32'd50;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("sat_inflight", 64'(inflight), 64'd2);
    check_val("sat_proto_err", 64'(proto_err), 64'(PROTO));
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("sat_both_inflight", 64'(inflight), 64'd2);
    do_reset();
    check_val("udf_pre", 64'(proto_err), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("udf_inflight", 64'(inflight), 64'd0);
    check_val("udf_proto_err", 64'(proto_err), 64'(PROTO));
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("udf_both_inflight", 64'(inflight), 64'd1);
    check_val("udf_both_proto_err", 64'(proto_err), 64'(PROTO));
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("full_both_no_err", 64'(proto_err), 64'd0);
    do_reset();

    // Random handshakes, limits and occasional resets
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 3))
        0:       limit = '0;
        1:       limit = 32'd2;
        2:       limit = 32'd3;
        default: limit = 32'd6;
      endcase
      for (int i = 0; i < 40; i++) begin
        reset = ($urandom_range(0, 29) == 0);
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      reset = 1'b0;
    end

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
